sc_matrix_max7219_tx: RTL and testbench

//  Display-side end of the main FSM's 8x8 LED-matrix row interface.

---
 rtl/sc_max7219_pkg.sv | 31 +++
 rtl/sc_max7219_frame_shifter.sv | 123 ++++++++++++
 rtl/sc_matrix_max7219_tx.sv | 175 +++++++++++++++++
 tb/tb_sc_matrix_max7219_tx.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_max7219_pkg.sv
// Shared constants for the MAX7219 matrix transmitter: register addresses,
// init word table and top-level FSM state encoding.
package sc_max7219_pkg;

  // MAX7219 register addresses
  localparam logic [7:0] DIGIT0  = 8'h01;
  localparam logic [7:0] DECODE  = 8'h09;
  localparam logic [7:0] INTENS  = 8'h0A;
  localparam logic [7:0] SCANLIM = 8'h0B;
  localparam logic [7:0] SHUTDN  = 8'h0C;
  localparam logic [7:0] TEST    = 8'h0F;

  localparam int unsigned INIT_WORDS = 5;

  // Top-level FSM encoding
  localparam logic [1:0] ST_INIT    = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_REFRESH = 2'd2;

  // Init sequence: test off, scan all 8 rows, no decode, intensity, leave shutdown
  function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] intensity);
    case (idx)
      3'd0:    return {TEST, 8'h00};
      3'd1:    return {SCANLIM, 8'h07};
      3'd2:    return {DECODE, 8'h00};
      3'd3:    return {INTENS, 4'h0, intensity};
      default: return {SHUTDN, 8'h01};
    endcase
  endfunction

endpackage

// File: rtl/sc_max7219_frame_shifter.sv
// Sends one 16-bit word MSB first on DIN/SCLK/CS_n. A frame is 34 half-periods:
// CS_n low setup, 16 SCLK high/low pairs, then a CS_n-high gap. A start seen in
// the last gap cycle chains the next frame with no extra idle time.
module sc_max7219_frame_shifter #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        SC_STATEMACHINE_MAIN_CLOCK_50,
  input  logic        SC_STATEMACHINE_MAIN_RESET_InHigh,
  input  logic        start,
  input  logic [15:0] word,
  output logic        done,
  output logic        din,
  output logic        sclk,
  output logic        cs_n
);

  localparam int unsigned HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);

  localparam logic [2:0] PH_IDLE  = 3'd0;
  localparam logic [2:0] PH_SETUP = 3'd1;
  localparam logic [2:0] PH_HIGH  = 3'd2;
  localparam logic [2:0] PH_LOW   = 3'd3;
  localparam logic [2:0] PH_GAP   = 3'd4;

  logic [2:0]    phase_q, phase_d;
  logic [HW-1:0] half_q, half_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   shift_q, shift_d;
  logic          din_q, din_d, sclk_q, sclk_d, cs_n_q, cs_n_d;
  logic          half_end;

  assign half_end = (half_q == HALF_LAST);
  assign done     = (phase_q == PH_GAP) && half_end;
  assign din      = din_q;
  assign sclk     = sclk_q;
  assign cs_n     = cs_n_q;

  // Phase sequencing; every phase lasts exactly one half-period
  always_comb begin
    phase_d = phase_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    din_d   = din_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    half_d  = (phase_q == PH_IDLE || half_end) ? '0 : half_q + HW'(1);
    case (phase_q)
      PH_IDLE: begin
        if (start) begin
          phase_d = PH_SETUP;
          cs_n_d  = 1'b0;
          din_d   = word[15];
          shift_d = word;
          bit_d   = 4'd15;
        end
      end
      PH_SETUP: begin
        if (half_end) begin
          phase_d = PH_HIGH;
          sclk_d  = 1'b1;
        end
      end
      PH_HIGH: begin
        // DIN only moves on the falling SCLK edge
        if (half_end) begin
          phase_d = PH_LOW;
          sclk_d  = 1'b0;
          din_d   = shift_q[14];
          shift_d = {shift_q[14:0], 1'b0};
        end
      end
      PH_LOW: begin
        if (half_end) begin
          if (bit_q == 4'd0) begin
            phase_d = PH_GAP;
            cs_n_d  = 1'b1;
          end else begin
            bit_d   = bit_q - 4'd1;
            phase_d = PH_HIGH;
            sclk_d  = 1'b1;
          end
        end
      end
      PH_GAP: begin
        if (half_end) begin
          if (start) begin
            phase_d = PH_SETUP;
            cs_n_d  = 1'b0;
            din_d   = word[15];
            shift_d = word;
            bit_d   = 4'd15;
          end else begin
            phase_d = PH_IDLE;
          end
        end
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  // State registers; reset forces the link idle immediately
  always_ff @(posedge SC_STATEMACHINE_MAIN_CLOCK_50 or posedge SC_STATEMACHINE_MAIN_RESET_InHigh) begin
    if (SC_STATEMACHINE_MAIN_RESET_InHigh) begin
      phase_q <= PH_IDLE;
      half_q  <= '0;
      bit_q   <= 4'd0;
      shift_q <= 16'h0000;
      din_q   <= 1'b0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
    end else begin
      phase_q <= phase_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      din_q   <= din_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
    end
  end

endmodule

// File: rtl/sc_matrix_max7219_tx.sv
// Display-side end of the 8x8 row interface: runs the MAX7219 init sequence,
// then sends one 8-row refresh per load. Loads arriving while busy are kept
// in a one-deep pending buffer (latest data wins) and served back-to-back.
module sc_matrix_max7219_tx import sc_max7219_pkg::*; #(
  parameter int unsigned CLK_DIV   = 4,
  parameter logic [3:0]  INTENSITY = 4'h8
) (
  input  logic       SC_STATEMACHINE_MAIN_CLOCK_50,
  input  logic       SC_STATEMACHINE_MAIN_RESET_InHigh,
  input  logic       load_InLow,
  input  logic [7:0] row_1_InBus,
  input  logic [7:0] row_2_InBus,
  input  logic [7:0] row_3_InBus,
  input  logic [7:0] row_4_InBus,
  input  logic [7:0] row_5_InBus,
  input  logic [7:0] row_6_InBus,
  input  logic [7:0] row_7_InBus,
  input  logic [7:0] row_8_InBus,
  output logic       busy_Out,
  output logic       pending_Out,
  output logic       max_din_Out,
  output logic       max_sclk_Out,
  output logic       max_cs_Out_n
);

  logic [1:0]  state_q, state_d;
  logic [2:0]  frame_q, frame_d;
  logic [2:0]  next_idx;
  logic        load_q, load_edge;
  logic        kick_q, kick_d;
  logic        pending_q, pending_d;
  logic [7:0]  rows [8];
  logic [7:0]  src [8];
  logic [7:0]  shadow_q [8];
  logic [7:0]  shadow_d [8];
  logic [7:0]  pend_buf_q [8];
  logic [7:0]  pend_buf_d [8];
  logic        start, done;
  logic [15:0] word;

  assign load_edge   = load_q & ~load_InLow;
  assign next_idx    = frame_q + 3'd1;
  assign busy_Out    = (state_q != ST_IDLE);
  assign pending_Out = pending_q;

  // Gather the row inputs and pick the source for the next refresh: a load in
  // this very cycle is newer than anything already pending
  always_comb begin
    rows[0] = row_1_InBus;
    rows[1] = row_2_InBus;
    rows[2] = row_3_InBus;
    rows[3] = row_4_InBus;
    rows[4] = row_5_InBus;
    rows[5] = row_6_InBus;
    rows[6] = row_7_InBus;
    rows[7] = row_8_InBus;
    for (int i = 0; i < 8; i++) src[i] = load_edge ? rows[i] : pend_buf_q[i];
  end

  // FSM: each frame is started in the cycle the previous one reports done
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    kick_d     = kick_q;
    pending_d  = pending_q;
    shadow_d   = shadow_q;
    pend_buf_d = pend_buf_q;
    start      = 1'b0;
    word       = 16'h0000;
    case (state_q)
      ST_INIT: begin
        if (load_edge) begin
          pend_buf_d = rows;
          pending_d  = 1'b1;
        end
        if (kick_q) begin
          start  = 1'b1;
          word   = init_word(3'd0, INTENSITY);
          kick_d = 1'b0;
        end else if (done) begin
          if (frame_q == 3'(INIT_WORDS - 1)) begin
            if (pending_q || load_edge) begin
              shadow_d  = src;
              pending_d = 1'b0;
              frame_d   = 3'd0;
              state_d   = ST_REFRESH;
              start     = 1'b1;
              word      = {DIGIT0, src[0]};
            end else begin
              frame_d = 3'd0;
              state_d = ST_IDLE;
            end
          end else begin
            frame_d = next_idx;
            start   = 1'b1;
            word    = init_word(next_idx, INTENSITY);
          end
        end
      end
      ST_IDLE: begin
        if (load_edge) begin
          shadow_d = rows;
          frame_d  = 3'd0;
          state_d  = ST_REFRESH;
          start    = 1'b1;
          word     = {DIGIT0, rows[0]};
        end
      end
      ST_REFRESH: begin
        if (load_edge) begin
          pend_buf_d = rows;
          pending_d  = 1'b1;
        end
        if (done) begin
          if (frame_q == 3'd7) begin
            if (pending_q || load_edge) begin
              shadow_d  = src;
              pending_d = 1'b0;
              frame_d   = 3'd0;
              start     = 1'b1;
              word      = {DIGIT0, src[0]};
            end else begin
              frame_d = 3'd0;
              state_d = ST_IDLE;
            end
          end else begin
            frame_d = next_idx;
            start   = 1'b1;
            word    = {DIGIT0 + {5'd0, next_idx}, shadow_q[next_idx]};
          end
        end
      end
      default: begin
        state_d = ST_INIT;
        kick_d  = 1'b1;
        frame_d = 3'd0;
      end
    endcase
  end

  // State, edge detector and row buffers
  always_ff @(posedge SC_STATEMACHINE_MAIN_CLOCK_50 or posedge SC_STATEMACHINE_MAIN_RESET_InHigh) begin
    if (SC_STATEMACHINE_MAIN_RESET_InHigh) begin
      state_q    <= ST_INIT;
      frame_q    <= 3'd0;
      kick_q     <= 1'b1;
      load_q     <= 1'b1;
      pending_q  <= 1'b0;
      shadow_q   <= '{default: 8'h00};
      pend_buf_q <= '{default: 8'h00};
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      kick_q     <= kick_d;
      load_q     <= load_InLow;
      pending_q  <= pending_d;
      shadow_q   <= shadow_d;
      pend_buf_q <= pend_buf_d;
    end
  end

  sc_max7219_frame_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .SC_STATEMACHINE_MAIN_CLOCK_50    (SC_STATEMACHINE_MAIN_CLOCK_50),
    .SC_STATEMACHINE_MAIN_RESET_InHigh(SC_STATEMACHINE_MAIN_RESET_InHigh),
    .start                            (start),
    .word                             (word),
    .done                             (done),
    .din                              (max_din_Out),
    .sclk                             (max_sclk_Out),
    .cs_n                             (max_cs_Out_n)
  );

endmodule

// File: tb/tb_sc_matrix_max7219_tx.sv
// Bench for sc_matrix_max7219_tx: two instances (CLK_DIV 4 and 2) share one
// stimulus stream; SPI slave monitors log words, and a timing-level model
// predicts busy/pending per cycle and the word stream of each instance.
module tb_sc_matrix_max7219_tx;

  localparam int HA = 4;
  localparam int HB = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b1;
  logic [7:0] row [8];
  logic       busy_a, pend_a, din_a, sclk_a, cs_a;
  logic       busy_b, pend_b, din_b, sclk_b, cs_b;

  always #10 clk = ~clk;

  sc_matrix_max7219_tx #(.CLK_DIV(HA), .INTENSITY(4'h8)) u_dut_a (
    .SC_STATEMACHINE_MAIN_CLOCK_50(clk), .SC_STATEMACHINE_MAIN_RESET_InHigh(rst),
    .load_InLow(load),
    .row_1_InBus(row[0]), .row_2_InBus(row[1]), .row_3_InBus(row[2]), .row_4_InBus(row[3]),
    .row_5_InBus(row[4]), .row_6_InBus(row[5]), .row_7_InBus(row[6]), .row_8_InBus(row[7]),
    .busy_Out(busy_a), .pending_Out(pend_a), .max_din_Out(din_a), .max_sclk_Out(sclk_a),
    .max_cs_Out_n(cs_a)
  );

  sc_matrix_max7219_tx #(.CLK_DIV(HB), .INTENSITY(4'h8)) u_dut_b (
    .SC_STATEMACHINE_MAIN_CLOCK_50(clk), .SC_STATEMACHINE_MAIN_RESET_InHigh(rst),
    .load_InLow(load),
    .row_1_InBus(row[0]), .row_2_InBus(row[1]), .row_3_InBus(row[2]), .row_4_InBus(row[3]),
    .row_5_InBus(row[4]), .row_6_InBus(row[5]), .row_7_InBus(row[6]), .row_8_InBus(row[7]),
    .busy_Out(busy_b), .pending_Out(pend_b), .max_din_Out(din_b), .max_sclk_Out(sclk_b),
    .max_cs_Out_n(cs_b)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          busy_end [2];
  bit          pend [2];
  logic [63:0] pend_rows [2];
  logic        prev_load = 1'b1;
  logic [15:0] exp_a [$];
  logic [15:0] exp_b [$];
  logic [15:0] log_a [$];
  logic [15:0] log_b [$];

  // SPI slave monitors, sampled on the falling system clock
  logic [15:0] sh_a, sh_b;
  int          bits_a, bits_b, low_a, low_b, high_a, high_b;
  int          vdin_a = 0, vdin_b = 0, vfrm_a = 0, vfrm_b = 0, vgap_a = 0, vgap_b = 0;
  logic        cs_pa = 1'b1, sclk_pa = 1'b0, din_pa = 1'b0;
  logic        cs_pb = 1'b1, sclk_pb = 1'b0, din_pb = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      bits_a <= 0; low_a <= 0; high_a <= 1000; sh_a <= 16'h0;
    end else begin
      if (!cs_a) begin
        low_a <= low_a + 1;
        if (sclk_a && !sclk_pa) begin
          sh_a   <= {sh_a[14:0], din_a};
          bits_a <= bits_a + 1;
        end
        if (din_a !== din_pa && !cs_pa && !(sclk_pa && !sclk_a)) vdin_a <= vdin_a + 1;
        if (cs_pa) begin
          if (high_a < HA) vgap_a <= vgap_a + 1;
          high_a <= 0;
        end
      end else begin
        high_a <= high_a + 1;
        if (!cs_pa) begin
          if (bits_a != 16 || low_a != 33 * HA) vfrm_a <= vfrm_a + 1;
          log_a.push_back(sh_a);
          bits_a <= 0;
          low_a  <= 0;
        end
      end
    end
    cs_pa <= cs_a; sclk_pa <= sclk_a; din_pa <= din_a;
  end

  always @(negedge clk) begin
    if (rst) begin
      bits_b <= 0; low_b <= 0; high_b <= 1000; sh_b <= 16'h0;
    end else begin
      if (!cs_b) begin
        low_b <= low_b + 1;
        if (sclk_b && !sclk_pb) begin
          sh_b   <= {sh_b[14:0], din_b};
          bits_b <= bits_b + 1;
        end
        if (din_b !== din_pb && !cs_pb && !(sclk_pb && !sclk_b)) vdin_b <= vdin_b + 1;
        if (cs_pb) begin
          if (high_b < HB) vgap_b <= vgap_b + 1;
          high_b <= 0;
        end
      end else begin
        high_b <= high_b + 1;
        if (!cs_pb) begin
          if (bits_b != 16 || low_b != 33 * HB) vfrm_b <= vfrm_b + 1;
          log_b.push_back(sh_b);
          bits_b <= 0;
          low_b  <= 0;
        end
      end
    end
    cs_pb <= cs_b; sclk_pb <= sclk_b; din_pb <= din_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int half(input int k);
    return (k == 0) ? HA : HB;
  endfunction

  function automatic logic [63:0] rows_now();
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[63 - 8 * i -: 8] = row[i];
    return r;
  endfunction

  task automatic push_word(input int k, input logic [15:0] w);
    if (k == 0) exp_a.push_back(w);
    else        exp_b.push_back(w);
  endtask

  task automatic push_refresh(input int k, input logic [63:0] r);
    for (int i = 0; i < 8; i++) push_word(k, {8'(i + 1), r[63 - 8 * i -: 8]});
  endtask

  task automatic model_reset();
    cyc = 0;
    prev_load = 1'b1;
    for (int k = 0; k < 2; k++) begin
      busy_end[k] = 5 * 34 * half(k) + 1;
      pend[k] = 1'b0;
      push_word(k, 16'h0F00); push_word(k, 16'h0B07); push_word(k, 16'h0900);
      push_word(k, 16'h0A08); push_word(k, 16'h0C01);
    end
  endtask

  // Behaviour of cycle cyc: a load when free starts a refresh next clock;
  // otherwise it overwrites the pending slot, which is drained on the last
  // busy cycle so the next refresh follows with no gap.
  task automatic model_cycle(input int k, input logic ld);
    if (prev_load && !ld) begin
      if (cyc >= busy_end[k]) begin
        push_refresh(k, rows_now());
        busy_end[k] = cyc + 1 + 8 * 34 * half(k);
      end else begin
        pend[k] = 1'b1;
        pend_rows[k] = rows_now();
      end
    end
    if (cyc == busy_end[k] - 1 && pend[k]) begin
      push_refresh(k, pend_rows[k]);
      busy_end[k] = cyc + 1 + 8 * 34 * half(k);
      pend[k] = 1'b0;
    end
  endtask

  task automatic tick(input logic ld);
    chk("busy_a", 32'(busy_a), 32'(cyc < busy_end[0]));
    chk("busy_b", 32'(busy_b), 32'(cyc < busy_end[1]));
    chk("pending_a", 32'(pend_a), 32'(pend[0]));
    chk("pending_b", 32'(pend_b), 32'(pend[1]));
    load = ld;
    model_cycle(0, ld);
    model_cycle(1, ld);
    prev_load = ld;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) tick(1'b1);
  endtask

  task automatic pulse();
    tick(1'b0);
    tick(1'b1);
  endtask

  task automatic rand_rows();
    for (int i = 0; i < 8; i++) row[i] = 8'($urandom);
  endtask

  task automatic settle();
    int guard = 0;
    while ((cyc < busy_end[0] + 4 || cyc < busy_end[1] + 4) && guard < 30000) begin
      tick(1'b1);
      guard++;
    end
    chk("settle_bound", 32'(guard < 30000), 32'd1);
  endtask

  task automatic compare_logs(input string tag);
    chk({tag, "_count_a"}, 32'(log_a.size()), 32'(exp_a.size()));
    for (int i = 0; i < log_a.size() && i < exp_a.size(); i++)
      chk({tag, "_word_a"}, {16'h0, log_a[i]}, {16'h0, exp_a[i]});
    chk({tag, "_count_b"}, 32'(log_b.size()), 32'(exp_b.size()));
    for (int i = 0; i < log_b.size() && i < exp_b.size(); i++)
      chk({tag, "_word_b"}, {16'h0, log_b[i]}, {16'h0, exp_b[i]});
    log_a.delete(); exp_a.delete(); log_b.delete(); exp_b.delete();
  endtask

  initial begin
    int g;
    for (int i = 0; i < 8; i++) row[i] = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cs_a", 32'(cs_a), 32'd1);
    chk("rst_sclk_a", 32'(sclk_a), 32'd0);
    chk("rst_din_a", 32'(din_a), 32'd0);
    chk("rst_busy_a", 32'(busy_a), 32'd1);
    chk("rst_pending_a", 32'(pend_a), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    model_reset();

    // Init sequence alone
    settle();
    compare_logs("init");

    // Fixed glyph refresh
    row[0] = 8'h00; row[1] = 8'h18; row[2] = 8'h38; row[3] = 8'h18;
    row[4] = 8'h18; row[5] = 8'h18; row[6] = 8'h3C; row[7] = 8'h00;
    pulse();
    settle();
    compare_logs("glyph");

    // Second load 300 clocks into a refresh
    rand_rows();
    pulse();
    run(298);
    for (int i = 0; i < 8; i++) row[i] = 8'hFF;
    pulse();
    settle();
    compare_logs("pend_ff");

    // Three loads during one refresh: only the last survives
    rand_rows();
    pulse();
    run(100);
    for (int i = 0; i < 8; i++) row[i] = 8'hAA;
    pulse();
    run(100);
    for (int i = 0; i < 8; i++) row[i] = 8'h55;
    pulse();
    run(100);
    for (int i = 0; i < 8; i++) row[i] = 8'hC3;
    pulse();
    settle();
    compare_logs("triple");

    // Load held low for a long time
    rand_rows();
    repeat (5000) tick(1'b0);
    tick(1'b1);
    settle();
    compare_logs("held");

    // Load edge in the same cycle the refresh ends
    rand_rows();
    pulse();
    while (cyc < busy_end[0] - 1) tick(1'b1);
    rand_rows();
    pulse();
    settle();
    compare_logs("end_edge");

    // Random loads at random spacing
    for (int n = 0; n < 6; n++) begin
      rand_rows();
      run($urandom_range(0, 1500));
      pulse();
    end
    settle();
    compare_logs("random");

    // Reset while SCLK is high mid-frame
    rand_rows();
    pulse();
    run(400);
    g = 0;
    while (!sclk_a && g < 100) begin
      tick(1'b1);
      g++;
    end
    chk("sclk_high_found", 32'(sclk_a), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_cs_a", 32'(cs_a), 32'd1);
    chk("midrst_sclk_a", 32'(sclk_a), 32'd0);
    chk("midrst_din_a", 32'(din_a), 32'd0);
    chk("midrst_cs_b", 32'(cs_b), 32'd1);
    chk("midrst_sclk_b", 32'(sclk_b), 32'd0);
    chk("midrst_busy_a", 32'(busy_a), 32'd1);
    chk("prefix_len_a", 32'(log_a.size() <= exp_a.size()), 32'd1);
    for (int i = 0; i < log_a.size() && i < exp_a.size(); i++)
      chk("prefix_word_a", {16'h0, log_a[i]}, {16'h0, exp_a[i]});
    chk("prefix_len_b", 32'(log_b.size() <= exp_b.size()), 32'd1);
    for (int i = 0; i < log_b.size() && i < exp_b.size(); i++)
      chk("prefix_word_b", {16'h0, log_b[i]}, {16'h0, exp_b[i]});
    log_a.delete(); exp_a.delete(); log_b.delete(); exp_b.delete();
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    model_reset();
    // Load during init is served right after init
    run(200);
    rand_rows();
    pulse();
    settle();
    compare_logs("reinit");

    chk("din_rule_a", 32'(vdin_a), 32'd0);
    chk("din_rule_b", 32'(vdin_b), 32'd0);
    chk("frame_len_a", 32'(vfrm_a), 32'd0);
    chk("frame_len_b", 32'(vfrm_b), 32'd0);
    chk("cs_gap_a", 32'(vgap_a), 32'd0);
    chk("cs_gap_b", 32'(vgap_b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
